alu_unit: RTL and testbench

ALU_UNIT -- requirements
Module: alu_unit

---
 rtl/alu_unit_pkg.sv | 80 ++++++++
 rtl/alu_decoder.sv | 44 ++++
 rtl/alu_unit.sv | 72 +++++++
 tb/tb_alu_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_unit_pkg.sv
// Shared constants and types for the RV32I ALU: opcodes, funct3 fields,
// the instruction bit-30 select, ALUop encodings and a decode helper.
package alu_unit_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned OPC_W   = 7;
    localparam int unsigned F3_W    = 3;
    localparam int unsigned ALUOP_W = 4;

    // RISC-V major opcodes
    localparam logic [OPC_W-1:0] OPC_LUI       = 7'b0110111;
    localparam logic [OPC_W-1:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [OPC_W-1:0] OPC_JAL       = 7'b1101111;
    localparam logic [OPC_W-1:0] OPC_JALR      = 7'b1100111;
    localparam logic [OPC_W-1:0] OPC_LOAD      = 7'b0000011;
    localparam logic [OPC_W-1:0] OPC_STORE     = 7'b0100011;
    localparam logic [OPC_W-1:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [OPC_W-1:0] OPC_ARI_ITYPE = 7'b0010011;
    localparam logic [OPC_W-1:0] OPC_ARI_RTYPE = 7'b0110011;

    // Branch funct3 values
    localparam logic [F3_W-1:0] F3_BEQ  = 3'b000;
    localparam logic [F3_W-1:0] F3_BNE  = 3'b001;
    localparam logic [F3_W-1:0] F3_BLT  = 3'b100;
    localparam logic [F3_W-1:0] F3_BGE  = 3'b101;
    localparam logic [F3_W-1:0] F3_BLTU = 3'b110;
    localparam logic [F3_W-1:0] F3_BGEU = 3'b111;

    // Integer arithmetic funct3 values
    localparam logic [F3_W-1:0] F3_ADD  = 3'b000;
    localparam logic [F3_W-1:0] F3_SLL  = 3'b001;
    localparam logic [F3_W-1:0] F3_SLT  = 3'b010;
    localparam logic [F3_W-1:0] F3_SLTU = 3'b011;
    localparam logic [F3_W-1:0] F3_XOR  = 3'b100;
    localparam logic [F3_W-1:0] F3_SR   = 3'b101;
    localparam logic [F3_W-1:0] F3_OR   = 3'b110;
    localparam logic [F3_W-1:0] F3_AND  = 3'b111;

    // Instruction bit 30 value selecting SUB / SRA
    localparam logic B30_SUB_SRA = 1'b1;

    // ALUop encodings; codes 11-15 are unused
    typedef enum logic [ALUOP_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9,
        ALU_LUI  = 4'd10
    } alu_op_e;

    // Shared funct3 decode for the I-type and R-type arithmetic groups.
    // sub_en allows bit 30 to turn ADD into SUB (R-type only).
    function automatic alu_op_e arith_op(
        input logic [F3_W-1:0] f3,
        input logic            bit30,
        input logic            sub_en
    );
        alu_op_e op;
        op = ALU_ADD;
        case (f3)
            F3_ADD:  op = (sub_en && (bit30 == B30_SUB_SRA)) ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = (bit30 == B30_SUB_SRA) ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            F3_AND:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALUop decoder: opcode, funct3 and bit 30 -> alu_op.
module alu_decoder
    import alu_unit_pkg::*;
(
    input  logic [OPC_W-1:0] opcode,
    input  logic [F3_W-1:0]  funct,
    input  logic             add_rshift_type,
    output alu_op_e          alu_op
);

    // Branch compare selection; bit 30 is ignored for branches
    alu_op_e branch_op;

    always_comb begin
        branch_op = ALU_SUB;
        case (funct)
            F3_BEQ:  branch_op = ALU_SUB;
            F3_BNE:  branch_op = ALU_XOR;
            F3_BLT:  branch_op = ALU_SLT;
            F3_BGE:  branch_op = ALU_SLT;
            F3_BLTU: branch_op = ALU_SLTU;
            F3_BGEU: branch_op = ALU_SLTU;
            default: branch_op = ALU_SUB;
        endcase
    end

    // Major opcode dispatch; unknown opcodes fall back to ADD
    always_comb begin
        alu_op = ALU_ADD;
        case (opcode)
            OPC_LUI:       alu_op = ALU_LUI;
            OPC_AUIPC,
            OPC_JAL,
            OPC_JALR,
            OPC_LOAD,
            OPC_STORE:     alu_op = ALU_ADD;
            OPC_BRANCH:    alu_op = branch_op;
            OPC_ARI_ITYPE: alu_op = arith_op(funct, add_rshift_type, 1'b0);
            OPC_ARI_RTYPE: alu_op = arith_op(funct, add_rshift_type, 1'b1);
            default:       alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/alu_unit.sv
// RV32I ALU: combinational decode, one-cycle registered result and Zero flag.
// Optional feature: define ALU_SHIFT_EN to implement SLL/SRL/SRA; without it
// the shift ALUop codes still decode but produce a zero result.
module alu_unit
    import alu_unit_pkg::*;
(
    input  logic               Clock,
    input  logic               Reset,
    input  logic [OPC_W-1:0]   opcode,
    input  logic [F3_W-1:0]    funct,
    input  logic               add_rshift_type,
    input  logic [XLEN-1:0]    A,
    input  logic [XLEN-1:0]    B,
    output logic [ALUOP_W-1:0] ALUop,
    output logic [XLEN-1:0]    Out,
    output logic               Zero
);

    alu_op_e         alu_op;
    logic [XLEN-1:0] result;

`ifdef ALU_SHIFT_EN
    logic [4:0] shamt;
    assign shamt = B[4:0];
`endif

    alu_decoder u_decoder (
        .opcode          (opcode),
        .funct           (funct),
        .add_rshift_type (add_rshift_type),
        .alu_op          (alu_op)
    );

    assign ALUop = alu_op;

    // Datapath: result for the decoded operation
    always_comb begin
        result = '0;
        case (alu_op)
            ALU_ADD:  result = A + B;
            ALU_SUB:  result = A - B;
            ALU_AND:  result = A & B;
            ALU_OR:   result = A | B;
            ALU_XOR:  result = A ^ B;
            ALU_SLT:  result = XLEN'($signed(A) < $signed(B));
            ALU_SLTU: result = XLEN'(A < B);
`ifdef ALU_SHIFT_EN
            ALU_SLL:  result = A << shamt;
            ALU_SRL:  result = A >> shamt;
            ALU_SRA:  result = XLEN'($unsigned($signed(A) >>> shamt));
`else
            ALU_SLL,
            ALU_SRL,
            ALU_SRA:  result = '0;
`endif
            ALU_LUI:  result = B << 12;
            default:  result = '0;
        endcase
    end

    // Output registers; reset wins over the new result
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Out  <= '0;
            Zero <= 1'b1;
        end else begin
            Out  <= result;
            Zero <= (result == '0);
        end
    end

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed vector table, multi-cycle reset
// sequence, branch-equality sweep and randomized checks against a reference model.
module tb_alu_unit;

`ifdef ALU_SHIFT_EN
    localparam bit SHIFT_EN = 1'b1;
`else
    localparam bit SHIFT_EN = 1'b0;
`endif

    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] ITYPE  = 7'b0010011;
    localparam logic [6:0] RTYPE  = 7'b0110011;

    logic        Clock;
    logic        Reset;
    logic [6:0]  opcode;
    logic [2:0]  funct;
    logic        add_rshift_type;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  ALUop;
    logic [31:0] Out;
    logic        Zero;

    int checks = 0;
    int errors = 0;

    alu_unit dut (
        .Clock           (Clock),
        .Reset           (Reset),
        .opcode          (opcode),
        .funct           (funct),
        .add_rshift_type (add_rshift_type),
        .A               (A),
        .B               (B),
        .ALUop           (ALUop),
        .Out             (Out),
        .Zero            (Zero)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        string       name;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        b30;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] out;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Operation the instruction asks for, as an ALUop number
    function automatic int model_op(input logic [6:0] opc, input logic [2:0] f3, input logic b30);
        if (opc == LUI) return 10;
        if (opc == AUIPC || opc == JAL || opc == JALR || opc == LOAD || opc == STORE) return 0;
        if (opc == BRANCH) begin
            if (f3 == 3'b001) return 4;
            if (f3 == 3'b100 || f3 == 3'b101) return 5;
            if (f3 == 3'b110 || f3 == 3'b111) return 6;
            return 1;
        end
        if (opc == ITYPE || opc == RTYPE) begin
            case (f3)
                3'b000:  return (opc == RTYPE && b30) ? 1 : 0;
                3'b001:  return 7;
                3'b010:  return 5;
                3'b011:  return 6;
                3'b100:  return 4;
                3'b101:  return b30 ? 9 : 8;
                3'b110:  return 3;
                default: return 2;
            endcase
        end
        return 0;
    endfunction

    // Arithmetic meaning of each operation, via 64-bit integer math
    function automatic logic [31:0] model_res(input int op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] wide;
        logic [63:0] pow;
        pow = 64'd1 << b[4:0];
        case (op)
            0:  begin wide = {32'd0, a} + {32'd0, b}; return wide[31:0]; end
            1:  begin wide = {32'd1, a} - {32'd0, b}; return wide[31:0]; end
            2:  return a & b;
            3:  return a | b;
            4:  return a ^ b;
            5:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6:  return (a < b) ? 32'd1 : 32'd0;
            7:  begin
                    if (!SHIFT_EN) return 32'd0;
                    wide = {32'd0, a} * pow;
                    return wide[31:0];
                end
            8:  begin
                    if (!SHIFT_EN) return 32'd0;
                    wide = {32'd0, a} / pow;
                    return wide[31:0];
                end
            9:  begin
                    if (!SHIFT_EN) return 32'd0;
                    // floor division of a negative value: ~((~a) / 2^sh)
                    if (a[31]) begin
                        wide = {32'd0, ~a} / pow;
                        return ~wide[31:0];
                    end
                    wide = {32'd0, a} / pow;
                    return wide[31:0];
                end
            10: begin wide = {32'd0, b} * 64'd4096; return wide[31:0]; end
            default: return 32'd0;
        endcase
    endfunction

    function automatic vec_t mk(input string name, input logic [6:0] opc, input logic [2:0] f3,
                                input logic b30, input logic [31:0] a, input logic [31:0] b,
                                input logic [3:0] op, input logic [31:0] out);
        vec_t v;
        v.name = name; v.opc = opc; v.f3 = f3; v.b30 = b30;
        v.a = a; v.b = b; v.op = op; v.out = out;
        return v;
    endfunction

    task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic b30,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge Clock);
        opcode = opc; funct = f3; add_rshift_type = b30; A = a; B = b;
    endtask

    // Drive one instruction, check ALUop now and Out/Zero after the next edge
    task automatic run_one(input string name, input logic [6:0] opc, input logic [2:0] f3,
                           input logic b30, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] op, input logic [31:0] out);
        drive(opc, f3, b30, a, b);
        #1;
        check({name, " aluop"}, {28'd0, ALUop}, {28'd0, op});
        @(posedge Clock);
        #1;
        check({name, " out"}, Out, out);
        check({name, " zero"}, {31'd0, Zero}, {31'd0, (out == 32'd0)});
    endtask

    initial begin
        logic [6:0] opcs [10];
        logic [6:0]  r_opc;
        logic [2:0]  r_f3;
        logic        r_b30;
        logic [31:0] r_a;
        logic [31:0] r_b;
        int          exp_op;

        opcs = '{LUI, AUIPC, JAL, JALR, LOAD, STORE, BRANCH, ITYPE, RTYPE, 7'h7F};

        // Reset state, and ALUop stays combinational while in reset
        Reset = 1'b1;
        opcode = LUI; funct = 3'd0; add_rshift_type = 1'b0; A = 32'd0; B = 32'd1;
        repeat (2) @(posedge Clock);
        #1;
        check("reset out", Out, 32'd0);
        check("reset zero", {31'd0, Zero}, 32'd1);
        check("reset aluop", {28'd0, ALUop}, 32'd10);
        @(negedge Clock);
        Reset = 1'b0;

        // Directed vector table
        vecs.push_back(mk("auipc", AUIPC, 3'($urandom_range(7)), 1'($urandom_range(1)),
                          32'h80000005, 32'hFFFF8123, 4'd0, 32'h7FFF8128));
        vecs.push_back(mk("lui", LUI, 3'($urandom_range(7)), 1'($urandom_range(1)),
                          $urandom, 32'h00012345, 4'd10, 32'h12345000));
        vecs.push_back(mk("r add", RTYPE, 3'b000, 1'b0, 32'd12, 32'hFFFF8000, 4'd0, 32'hFFFF800C));
        vecs.push_back(mk("r sub", RTYPE, 3'b000, 1'b1, 32'd12, 32'hFFFF8000, 4'd1, 32'h0000800C));
        vecs.push_back(mk("blt", BRANCH, 3'b100, 1'b0, 32'h80000000, 32'd1, 4'd5, 32'd1));
        vecs.push_back(mk("bltu", BRANCH, 3'b110, 1'b1, 32'h80000000, 32'd1, 4'd6, 32'd0));
        vecs.push_back(mk("i sra", ITYPE, 3'b101, 1'b1, 32'h80000000, 32'h24, 4'd9,
                          SHIFT_EN ? 32'hF8000000 : 32'd0));
        vecs.push_back(mk("i add b30", ITYPE, 3'b000, 1'b1, 32'd5, 32'd7, 4'd0, 32'd12));
        vecs.push_back(mk("jal", JAL, 3'b010, 1'b1, 32'h100, 32'd4, 4'd0, 32'h104));
        vecs.push_back(mk("i and", ITYPE, 3'b111, 1'b0, 32'h0000F0F0, 32'h0000FF00, 4'd2, 32'h0000F000));
        vecs.push_back(mk("r or", RTYPE, 3'b110, 1'b1, 32'h0000F0F0, 32'h0000FF00, 4'd3, 32'h0000FFF0));
        vecs.push_back(mk("i sll", ITYPE, 3'b001, 1'b0, 32'd1, 32'h21, 4'd7, SHIFT_EN ? 32'd2 : 32'd0));
        vecs.push_back(mk("r srl", RTYPE, 3'b101, 1'b0, 32'h80000000, 32'd4, 4'd8,
                          SHIFT_EN ? 32'h08000000 : 32'd0));
        vecs.push_back(mk("other op", 7'h7F, 3'b101, 1'b1, 32'd1, 32'd2, 4'd0, 32'd3));
        vecs.push_back(mk("bne", BRANCH, 3'b001, 1'b1, 32'hFF, 32'h0F, 4'd4, 32'hF0));
        vecs.push_back(mk("br 010", BRANCH, 3'b010, 1'b0, 32'd5, 32'd3, 4'd1, 32'd2));
        vecs.push_back(mk("r sltu", RTYPE, 3'b011, 1'b0, 32'd3, 32'hFFFFFFFF, 4'd6, 32'd1));
        vecs.push_back(mk("store wrap", STORE, 3'b010, 1'b0, 32'hFFFFFFFF, 32'd1, 4'd0, 32'd0));

        foreach (vecs[i])
            run_one(vecs[i].name, vecs[i].opc, vecs[i].f3, vecs[i].b30,
                    vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].out);

        // Equal operands give zero for every branch compare
        for (int f = 0; f < 8; f++)
            run_one($sformatf("beq sweep f%0d", f), BRANCH, 3'(f), 1'($urandom_range(1)),
                    32'h10, 32'h10, 4'(model_op(BRANCH, 3'(f), 1'b0)), 32'd0);

        // Reset overrides a nonzero result for one edge, then the result loads
        drive(RTYPE, 3'b000, 1'b0, 32'd5, 32'd6);
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        check("rst seq out", Out, 32'd0);
        check("rst seq zero", {31'd0, Zero}, 32'd1);
        @(negedge Clock);
        Reset = 1'b0;
        @(posedge Clock);
        #1;
        check("post rst out", Out, 32'd11);
        check("post rst zero", {31'd0, Zero}, 32'd0);

        // Randomized instructions against the reference model
        for (int n = 0; n < 400; n++) begin
            r_opc = opcs[$urandom_range(9)];
            if (r_opc == 7'h7F) r_opc = 7'($urandom);
            r_f3  = 3'($urandom);
            r_b30 = 1'($urandom);
            r_a   = $urandom;
            case ($urandom_range(3))
                0:       r_b = r_a;
                1:       r_b = 32'($urandom_range(64));
                default: r_b = $urandom;
            endcase
            exp_op = model_op(r_opc, r_f3, r_b30);
            run_one($sformatf("rand%0d op%h f%0d", n, r_opc, r_f3), r_opc, r_f3, r_b30,
                    r_a, r_b, 4'(exp_op), model_res(exp_op, r_a, r_b));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
